comparator: RTL and testbench
=============================

COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: number of scores per frame.
REQ-002 SHALL have parameter DATA_BITS, default 12: width of each signed score.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_in  input  1  score beat strobe from the fully connected stage.
REQ-006 SHALL have port data_in  input  DATA_BITS  signed two's-complement class score.
REQ-007 SHALL have port decision  output  4  index of winning class.
REQ-008 SHALL have port valid_out  output  1  one-cycle pulse, decision updated.
REQ-009 SHALL have port busy  output  1  high while a frame is partially received.

Function
REQ-010 SHALL number beats in arrival order: index 0..NUM_CLASSES-1 per frame, counted only on cycles with valid_in=1; idle gaps of any length are allowed between beats.
REQ-011 SHALL implement states IDLE, ACCUM and DONE:
- IDLE -> ACCUM on the first beat.
- ACCUM -> DONE on beat NUM_CLASSES-1.
- DONE -> IDLE after one cycle.
REQ-012 SHALL, on beat 0, load the running max with data_in and the running index with 0, without comparing against the previous frame.
REQ-013 SHALL, on beats 1..NUM_CLASSES-1, update the running max and index only when data_in > running max (signed, strict).
REQ-014 SHALL, on a tie, keep the lowest index.
REQ-015 SHALL register decision and assert valid_out for exactly one cycle, in the cycle after the final beat is sampled.
REQ-016 SHALL hold decision stable until the next frame completes.
REQ-017 SHALL, on a beat arriving in DONE, treat it as beat 0 of the next frame; back-to-back frames with no gap lose no data.
REQ-018 SHALL hold busy=1 in ACCUM and 0 in IDLE/DONE.
REQ-019 SHALL wrap the beat counter to 0 after NUM_CLASSES-1; the counter never exceeds NUM_CLASSES-1.
REQ-020 SHALL perform all comparisons at DATA_BITS+1 bits, sign-extended; no saturation is needed.

Reset
REQ-021 SHALL, on rst_n low, immediately set decision=0, valid_out=0, busy=0, state=IDLE, beat counter=0, running max=most-negative value.
REQ-022 SHALL discard any partial frame on reset mid-frame; the first valid_in after release is beat 0.
REQ-023 SHALL produce no valid_out in the cycle of reset release.

Configuration
REQ-024 SHALL, when COMPARATOR_MARGIN_EN is defined:
- add output margin, width DATA_BITS+1, unsigned = max score minus second-highest score;
- track the second max in parallel, where a tie with the max gives margin 0;
- register margin alongside decision; reset value 0.
REQ-025 SHALL, when COMPARATOR_MARGIN_EN is undefined, have no margin port and no second-max logic; all other behaviour is identical.

Structure
REQ-026 SHALL take from the shared cnn package:
- NUM_CLASSES;
- DATA_BITS;
- the state enumeration (IDLE/ACCUM/DONE);
- the constant for the most-negative score.
REQ-027 SHALL be a single module with no sub-module.

Verification
REQ-028 SHALL cover distinct maximum: scores {-5,3,100,7,0,-1,2,9,4,1}, gapless -> decision=2, valid_out one pulse 1 cycle after the 10th beat; with the margin macro, margin=91.
REQ-029 SHALL cover tie and all-negative frames:
- scores all -2048 -> decision=0 (margin 0);
- scores with 50 at indices 3 and 8 -> decision=3.
REQ-030 SHALL cover gapped beats: the same frame as REQ-028 with 0-3 random idle cycles between beats -> decision=2, busy high from the first beat until the final beat.
REQ-031 SHALL cover back-to-back frames: frame A max at 9, then frame B max at 0, no idle cycle -> two valid_out pulses, 10 cycles apart, decisions 9 then 0.
REQ-032 SHALL cover reset mid-frame: rst_n low after beat 5, released, then a full frame with max at index 6 -> single valid_out, decision=6, no pulse from the aborted frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN package: frame geometry, score width, comparator state enumeration
// and the most-negative score constant used to initialise running maxima.
package cnn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_BITS   = 12;
  localparam int IDX_BITS    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic signed [DATA_BITS-1:0] SCORE_MIN = {1'b1, {(DATA_BITS-1){1'b0}}};

endpackage

// File: rtl/comparator.sv
// Argmax over NUM_CLASSES signed score beats; one-cycle valid_out after the last beat.
// COMPARATOR_MARGIN_EN adds a registered max-minus-second-max margin output.
module comparator
  import cnn_pkg::*;
#(
  parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
  parameter int DATA_BITS   = cnn_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [3:0]           decision,
  output logic                 valid_out,
  output logic                 busy
`ifdef COMPARATOR_MARGIN_EN
  ,
  output logic [DATA_BITS:0]   margin
`endif
);

  localparam logic [3:0] LAST_BEAT = 4'(NUM_CLASSES - 1);
  localparam logic signed [DATA_BITS:0] MIN_EXT = (DATA_BITS+1)'(SCORE_MIN);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] dec_q, dec_d;
  logic       vout_q, vout_d;
  logic signed [DATA_BITS:0] max_q, max_d;
  logic signed [DATA_BITS:0] din_ext;
  logic first_beat, last_beat;

  assign din_ext    = signed'({data_in[DATA_BITS-1], data_in});
  assign first_beat = (cnt_q == 4'd0);
  assign last_beat  = (cnt_q == LAST_BEAT);

`ifdef COMPARATOR_MARGIN_EN
  logic signed [DATA_BITS:0] sec_q, sec_d;
  logic [DATA_BITS:0]        marg_q, marg_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    max_d   = max_q;
    dec_d   = dec_q;
    vout_d  = 1'b0;
`ifdef COMPARATOR_MARGIN_EN
    sec_d   = sec_q;
    marg_d  = marg_q;
`endif
    if (state_q == DONE) state_d = IDLE;

    if (valid_in) begin
      // Beat 0 always reloads, so a beat landing in DONE starts the next frame cleanly.
      if (first_beat) begin
        max_d = din_ext;
        idx_d = 4'd0;
`ifdef COMPARATOR_MARGIN_EN
        sec_d = MIN_EXT;
`endif
      end else if (din_ext > max_q) begin
        max_d = din_ext;
        idx_d = cnt_q;
`ifdef COMPARATOR_MARGIN_EN
        sec_d = max_q;
      end else if (din_ext > sec_q) begin
        sec_d = din_ext;
`endif
      end

      if (last_beat) begin
        cnt_d   = 4'd0;
        state_d = DONE;
        dec_d   = idx_d;
        vout_d  = 1'b1;
`ifdef COMPARATOR_MARGIN_EN
        marg_d  = max_d - sec_d;
`endif
      end else begin
        cnt_d   = cnt_q + 4'd1;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      dec_q   <= 4'd0;
      vout_q  <= 1'b0;
      max_q   <= MIN_EXT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      vout_q  <= vout_d;
      max_q   <= max_d;
    end
  end

`ifdef COMPARATOR_MARGIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q  <= MIN_EXT;
      marg_q <= '0;
    end else begin
      sec_q  <= sec_d;
      marg_q <= marg_d;
    end
  end

  assign margin = marg_q;
`endif

  assign decision  = dec_q;
  assign valid_out = vout_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed frames plus random frames
// compared against an argmax/margin reference model.
module tb_comparator;

  localparam int N  = 10;
  localparam int DB = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DB-1:0] data_in = '0;
  logic [3:0]    decision;
  logic          valid_out;
  logic          busy;
`ifdef COMPARATOR_MARGIN_EN
  logic [DB:0]   margin;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulse_cyc[$];
  int pulse_dec[$];

  comparator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .decision  (decision),
    .valid_out (valid_out),
    .busy      (busy)
`ifdef COMPARATOR_MARGIN_EN
    ,
    .margin    (margin)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out) begin
      pulse_cyc.push_back(cyc);
      pulse_dec.push_back(int'(decision));
    end
  end

  // Reference: first index holding the largest value.
  function automatic int ref_argmax(input int s[N]);
    int best = 0;
    for (int i = 1; i < N; i++) if (s[i] > s[best]) best = i;
    return best;
  endfunction

  // Reference: largest value minus the largest of the remaining values.
  function automatic int ref_margin(input int s[N]);
    int a = ref_argmax(s);
    int sec = -100000;
    for (int i = 0; i < N; i++) if (i != a && s[i] > sec) sec = s[i];
    return s[a] - sec;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends a frame with up to max_gap idle cycles between beats; optional busy checks.
  task automatic send_frame(input int s[N], input int max_gap, input bit chk_busy);
    for (int i = 0; i < N; i++) begin
      valid_in = 1'b1;
      data_in  = DB'(s[i]);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      if (i < N - 1) begin
        int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        if (chk_busy) begin
          n_cmp++;
          if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_mid beat=%0d got=%b exp=1", i, busy);
          end
        end
        for (int k = 0; k < g; k++) begin
          @(posedge clk);
          #1;
          if (chk_busy) begin
            n_cmp++;
            if (busy !== 1'b1) begin
              n_err++;
              $display("FAIL busy_gap beat=%0d got=%b exp=1", i, busy);
            end
          end
        end
      end
    end
  endtask

  task automatic check_done(input string name, input int s[N]);
    int exp_dec = ref_argmax(s);
    n_cmp++;
    if (valid_out !== 1'b1 || decision !== 4'(exp_dec)) begin
      n_err++;
      $display("FAIL %s_done got vo=%b dec=%0d exp vo=1 dec=%0d", name, valid_out, decision, exp_dec);
    end
`ifdef COMPARATOR_MARGIN_EN
    n_cmp++;
    if (margin !== (DB+1)'(ref_margin(s))) begin
      n_err++;
      $display("FAIL %s_margin got=%0d exp=%0d", name, margin, ref_margin(s));
    end
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    n_cmp++;
    if (decision !== 4'd0 || valid_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got dec=%0d vo=%b busy=%b exp 0/0/0", decision, valid_out, busy);
    end
`ifdef COMPARATOR_MARGIN_EN
    n_cmp++;
    if (margin !== '0) begin
      n_err++;
      $display("FAIL reset_margin got=%0d exp=0", margin);
    end
`endif
    rst_n = 1'b1;
    idle(1);
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_vo got=%b exp=0", valid_out);
    end
  endtask

  task automatic test_distinct;
    int s[N] = '{-5, 3, 100, 7, 0, -1, 2, 9, 4, 1};
    pulse_cyc.delete(); pulse_dec.delete();
    send_frame(s, 0, 1'b1);
    check_done("distinct", s);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL distinct_busy_done got=%b exp=0", busy);
    end
    idle(1);
    n_cmp++;
    if (valid_out !== 1'b0 || decision !== 4'd2) begin
      n_err++;
      $display("FAIL distinct_after got vo=%b dec=%0d exp vo=0 dec=2", valid_out, decision);
    end
    idle(5);
    n_cmp++;
    if (pulse_cyc.size() != 1 || decision !== 4'd2) begin
      n_err++;
      $display("FAIL distinct_hold got pulses=%0d dec=%0d exp 1/2", pulse_cyc.size(), decision);
    end
  endtask

  task automatic test_ties;
    int s[N];
    for (int i = 0; i < N; i++) s[i] = -2048;
    send_frame(s, 0, 1'b0);
    check_done("all_min", s);
    idle(2);
    for (int i = 0; i < N; i++) s[i] = int'($urandom_range(2097, 0)) - 2048;
    s[3] = 50;
    s[8] = 50;
    send_frame(s, 1, 1'b0);
    check_done("tie50", s);
    n_cmp++;
    if (decision !== 4'd3) begin
      n_err++;
      $display("FAIL tie50_index got=%0d exp=3", decision);
    end
    idle(2);
  endtask

  task automatic test_gapped;
    int s[N] = '{-5, 3, 100, 7, 0, -1, 2, 9, 4, 1};
    send_frame(s, 3, 1'b1);
    check_done("gapped", s);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL gapped_busy_done got=%b exp=0", busy);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    int a[N];
    int b[N];
    for (int i = 0; i < N; i++) begin
      a[i] = int'($urandom_range(1000, 0)) - 500;
      b[i] = int'($urandom_range(1000, 0)) - 500;
    end
    a[9] = 900;
    b[0] = 900;
    pulse_cyc.delete(); pulse_dec.delete();
    send_frame(a, 0, 1'b0);
    check_done("b2b_a", a);
    send_frame(b, 0, 1'b0);
    check_done("b2b_b", b);
    idle(3);
    n_cmp++;
    if (pulse_cyc.size() != 2) begin
      n_err++;
      $display("FAIL b2b_pulses got=%0d exp=2", pulse_cyc.size());
    end else begin
      n_cmp++;
      if (pulse_cyc[1] - pulse_cyc[0] != N || pulse_dec[0] != 9 || pulse_dec[1] != 0) begin
        n_err++;
        $display("FAIL b2b_timing got gap=%0d dec=%0d,%0d exp gap=10 dec=9,0",
                 pulse_cyc[1] - pulse_cyc[0], pulse_dec[0], pulse_dec[1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int s[N];
    for (int i = 0; i < N; i++) s[i] = int'($urandom_range(600, 0)) - 300;
    s[6] = 1000;
    pulse_cyc.delete(); pulse_dec.delete();
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1;
      data_in  = DB'(2000);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || decision !== 4'd0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_async got busy=%b dec=%0d vo=%b exp 0/0/0", busy, decision, valid_out);
    end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_frame(s, 2, 1'b0);
    check_done("midreset", s);
    idle(3);
    n_cmp++;
    if (pulse_cyc.size() != 1 || decision !== 4'd6) begin
      n_err++;
      $display("FAIL midreset_pulses got=%0d dec=%0d exp 1/6", pulse_cyc.size(), decision);
    end
  endtask

  task automatic test_random;
    int s[N];
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) s[i] = int'($urandom_range(4095, 0)) - 2048;
      if (f % 4 == 0) s[$urandom_range(N - 1, 0)] = s[$urandom_range(N - 1, 0)];
      send_frame(s, f % 3, 1'b0);
      check_done("random", s);
      if (f % 2 == 1) idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_ties();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
